// File: rtl/dpsk_pkg.sv
// Shared DPSK modulator constants and FSM state type.
package dpsk_pkg;

  localparam int unsigned PHASE_W  = 34;
  localparam int unsigned LUT_AW   = 6;
  localparam int unsigned SAMPLE_W = 8;

  // 6 MHz carrier at 32 MHz clk; the receiver uses the same increment
  localparam logic [PHASE_W-1:0] PHASE_INC_DEF = 34'd3221225472;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_DATA
  } state_t;

endpackage

// File: rtl/dpsk_sin_lut.sv
// 64-entry signed sine table, round(127*sin(2*pi*k/64)), registered read.
module dpsk_sin_lut
  import dpsk_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LUT_AW-1:0]          i_addr,
  output logic signed [SAMPLE_W-1:0] o_data
);

  logic signed [SAMPLE_W-1:0] w_val;
  logic signed [SAMPLE_W-1:0] r_data;

  always_comb begin
    w_val = '0;
    case (i_addr)
      6'd0:  w_val =  8'sd0;   6'd1:  w_val =  8'sd12;  6'd2:  w_val =  8'sd25;  6'd3:  w_val =  8'sd37;
      6'd4:  w_val =  8'sd49;  6'd5:  w_val =  8'sd60;  6'd6:  w_val =  8'sd71;  6'd7:  w_val =  8'sd81;
      6'd8:  w_val =  8'sd90;  6'd9:  w_val =  8'sd98;  6'd10: w_val =  8'sd106; 6'd11: w_val =  8'sd112;
      6'd12: w_val =  8'sd117; 6'd13: w_val =  8'sd122; 6'd14: w_val =  8'sd125; 6'd15: w_val =  8'sd126;
      6'd16: w_val =  8'sd127; 6'd17: w_val =  8'sd126; 6'd18: w_val =  8'sd125; 6'd19: w_val =  8'sd122;
      6'd20: w_val =  8'sd117; 6'd21: w_val =  8'sd112; 6'd22: w_val =  8'sd106; 6'd23: w_val =  8'sd98;
      6'd24: w_val =  8'sd90;  6'd25: w_val =  8'sd81;  6'd26: w_val =  8'sd71;  6'd27: w_val =  8'sd60;
      6'd28: w_val =  8'sd49;  6'd29: w_val =  8'sd37;  6'd30: w_val =  8'sd25;  6'd31: w_val =  8'sd12;
      6'd32: w_val =  8'sd0;   6'd33: w_val = -8'sd12;  6'd34: w_val = -8'sd25;  6'd35: w_val = -8'sd37;
      6'd36: w_val = -8'sd49;  6'd37: w_val = -8'sd60;  6'd38: w_val = -8'sd71;  6'd39: w_val = -8'sd81;
      6'd40: w_val = -8'sd90;  6'd41: w_val = -8'sd98;  6'd42: w_val = -8'sd106; 6'd43: w_val = -8'sd112;
      6'd44: w_val = -8'sd117; 6'd45: w_val = -8'sd122; 6'd46: w_val = -8'sd125; 6'd47: w_val = -8'sd126;
      6'd48: w_val = -8'sd127; 6'd49: w_val = -8'sd126; 6'd50: w_val = -8'sd125; 6'd51: w_val = -8'sd122;
      6'd52: w_val = -8'sd117; 6'd53: w_val = -8'sd112; 6'd54: w_val = -8'sd106; 6'd55: w_val = -8'sd98;
      6'd56: w_val = -8'sd90;  6'd57: w_val = -8'sd81;  6'd58: w_val = -8'sd71;  6'd59: w_val = -8'sd60;
      6'd60: w_val = -8'sd49;  6'd61: w_val = -8'sd37;  6'd62: w_val = -8'sd25;  6'd63: w_val = -8'sd12;
      default: w_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_data <= '0;
    else     r_data <= w_val;
  end

  assign o_data = r_data;

endmodule

// File: rtl/dpsk_mod.sv
// DPSK modulator: lead symbols, differentially encoded data, NCO sine carrier.
module dpsk_mod
  import dpsk_pkg::*;
#(
  parameter int unsigned          SYM_CYCLES = 32,
  parameter int unsigned          N_LEAD     = 4,
  parameter logic [PHASE_W-1:0]   PHASE_INC  = PHASE_INC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic                       dout_valid,
  output logic                       busy
);

  localparam logic [15:0] SYM_LAST  = 16'(SYM_CYCLES - 1);
  localparam logic [7:0]  LEAD_LAST = 8'(N_LEAD - 1);

  logic [PHASE_W-1:0]         r_phase;
  state_t                     r_state, w_state_nx;
  logic [15:0]                r_sym_cnt, w_sym_cnt_nx;
  logic [7:0]                 r_lead_cnt, w_lead_cnt_nx;
  logic                       r_enc, w_enc_nx;
  logic                       w_bnd, w_ready;
  logic signed [SAMPLE_W-1:0] w_lut;
  logic                       r_flag1, r_enc1;
  logic signed [SAMPLE_W-1:0] r_dout;
  logic                       r_dout_valid;

  // Free-running NCO, independent of the FSM
  always_ff @(posedge clk) begin
    if (rst) r_phase <= '0;
    else     r_phase <= r_phase + PHASE_INC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sym_cnt  <= '0;
      r_lead_cnt <= '0;
      r_enc      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_sym_cnt  <= w_sym_cnt_nx;
      r_lead_cnt <= w_lead_cnt_nx;
      r_enc      <= w_enc_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_sym_cnt_nx  = r_sym_cnt;
    w_lead_cnt_nx = r_lead_cnt;
    w_enc_nx      = r_enc;
    w_ready       = 1'b0;
    w_bnd         = (r_sym_cnt == SYM_LAST);
    case (r_state)
      ST_IDLE: begin
        w_enc_nx = 1'b0;
        if (din_valid) begin
          w_state_nx    = ST_LEAD;
          w_sym_cnt_nx  = '0;
          w_lead_cnt_nx = '0;
        end
      end
      ST_LEAD: begin
        if (w_bnd) begin
          w_sym_cnt_nx = '0;
          if (r_lead_cnt == LEAD_LAST) w_ready = 1'b1;
          else                         w_lead_cnt_nx = r_lead_cnt + 8'd1;
        end else begin
          w_sym_cnt_nx = r_sym_cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (w_bnd) begin
          w_sym_cnt_nx = '0;
          w_ready      = 1'b1;
        end else begin
          w_sym_cnt_nx = r_sym_cnt + 16'd1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // Accept point: a new bit starts the next data symbol, no bit ends the frame
    if (w_ready) begin
      if (din_valid) begin
        w_state_nx = ST_DATA;
        w_enc_nx   = r_enc ^ din;
      end else begin
        w_state_nx = ST_IDLE;
        w_enc_nx   = 1'b0;
      end
    end
  end

  dpsk_sin_lut u_lut (
    .clk    (clk),
    .rst    (rst),
    .i_addr (r_phase[PHASE_W-1 -: LUT_AW]),
    .o_data (w_lut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag1      <= 1'b0;
      r_enc1       <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_flag1      <= (r_state != ST_IDLE);
      r_enc1       <= r_enc;
      r_dout       <= r_flag1 ? (r_enc1 ? -w_lut : w_lut) : '0;
      r_dout_valid <= r_flag1;
    end
  end

  assign din_ready  = w_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dpsk_mod.sv
// Scoreboard bench for dpsk_mod: default build plus a SYM_CYCLES=2/N_LEAD=1 build.
module tb_dpsk_mod;

  localparam longint unsigned PH_INC  = 64'd3221225472;
  localparam longint unsigned PH_MASK = 64'h3_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, din, din_valid;
  logic signed [7:0] dout_a, dout_b;
  logic dv_a, dv_b, rdy_a, rdy_b, busy_a, busy_b;

  dpsk_mod u_dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_a),
    .dout(dout_a), .dout_valid(dv_a), .busy(busy_a)
  );

  dpsk_mod #(.SYM_CYCLES(2), .N_LEAD(1)) u_dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_b),
    .dout(dout_b), .dout_valid(dv_b), .busy(busy_b)
  );

  logic sel;
  logic signed [7:0] m_dout;
  logic m_dv, m_rdy, m_busy;
  assign m_dout = sel ? dout_b : dout_a;
  assign m_dv   = sel ? dv_b   : dv_a;
  assign m_rdy  = sel ? rdy_b  : rdy_a;
  assign m_busy = sel ? busy_b : busy_a;

  int sym_c, nl_c;
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef struct { int cyc; int val; } exp_t;
  exp_t sq[$];
  int   rq[$];
  int   busy_lo = -1, busy_hi = -1;
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0, lit_en = 1'b0;
  logic signed [7:0] cap [0:8191];
  bit   fbits [0:1023];
  int   rdy_tab [0:1024];

  task automatic chk(input string name, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int lut_idx(input int c);
    longint unsigned cc, p;
    cc = c;
    p  = (cc * PH_INC) & PH_MASK;
    return int'(p >> 28);
  endfunction

  function automatic int ref_sin(input int k);
    real v;
    v = 127.0 * $sin(2.0 * 3.141592653589793 * k / 64.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Monitor: compares every cycle against the expectation queues
  always @(negedge clk) begin
    bit ev, er;
    if (mon_en && !rst) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        chk("sample_lost", 0, sq[0].val);
        void'(sq.pop_front());
      end
      ev = (sq.size() > 0) && (sq[0].cyc == cyc);
      chk("dout_valid", m_dv, ev);
      if (ev) begin
        chk("dout", m_dout, sq[0].val);
        void'(sq.pop_front());
      end else begin
        chk("dout_idle", m_dout, 0);
      end
      er = (rq.size() > 0) && (rq[0] == cyc);
      if (er) void'(rq.pop_front());
      chk("din_ready", m_rdy, er);
      chk("busy", m_busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (sel && cyc < 8192) cap[cyc] = m_dout;
      if (lit_en) begin
        case (cyc)
          3:   chk("first_dout0", m_dout, 117);
          4:   chk("first_dout1", m_dout, 90);
          5:   chk("first_dout2", m_dout, -49);
          127: chk("ready_early", m_rdy, 0);
          128: chk("ready_first", m_rdy, 1);
          default: ;
        endcase
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_dout", m_dout, 0);
    chk("rst_dout_valid", m_dv, 0);
    chk("rst_din_ready", m_rdy, 0);
    chk("rst_busy", m_busy, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    din_valid = 1'b0;
    sq.delete();
    rq.delete();
    busy_lo = -1;
    busy_hi = -1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      din = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input int k);
    for (int i = 0; i < k; i++) fbits[i] = 1'($urandom);
  endtask

  // One frame of k bits starting now; expectations come from symbol timing
  task automatic run_frame(input int k, input int abort_at);
    int s, enc, c, v;
    s   = cyc;
    enc = 0;
    for (int m = 0; m < nl_c + k; m++) begin
      if (m >= nl_c) enc = enc ^ int'(fbits[m - nl_c]);
      for (int t = 0; t < sym_c; t++) begin
        c = s + 1 + m * sym_c + t;
        v = ref_sin(lut_idx(c));
        sq.push_back('{c + 2, (enc != 0) ? -v : v});
      end
    end
    for (int j = 0; j <= k; j++) begin
      rdy_tab[j] = s + (nl_c + j) * sym_c;
      rq.push_back(rdy_tab[j]);
    end
    busy_lo = s + 1;
    busy_hi = rdy_tab[k];
    for (int n = 0; n <= rdy_tab[k] + 3 - s; n++) begin
      if (abort_at >= 0 && cyc == abort_at) begin
        do_reset(1);
        check_reset_outputs();
        return;
      end
      din_valid = (cyc <= rdy_tab[k-1]);
      din = 1'($urandom);
      for (int j = 0; j < k; j++) if (rdy_tab[j] == cyc) din = fbits[j];
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
  endtask

  initial begin
    int k, corr, e, eprev, bitv;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; sel = 1'b0;
    sym_c = 32; nl_c = 4;
    do_reset(3);
    mon_en = 1'b1;
    check_reset_outputs();

    fbits[0] = 1'b1; fbits[1] = 1'b1; fbits[2] = 1'b0; fbits[3] = 1'b1;
    lit_en = 1'b1;
    run_frame(4, -1);
    lit_en = 1'b0;
    idle(5);

    fill(2);
    run_frame(2, -1);
    idle(3);

    do_reset(2);
    check_reset_outputs();
    idle(40);

    repeat (4) begin
      k = $urandom_range(1, 6);
      fill(k);
      run_frame(k, -1);
      idle($urandom_range(0, 10));
    end

    fill(5);
    run_frame(5, cyc + 1 + (nl_c + 2) * sym_c + 17);
    fill(3);
    run_frame(3, -1);
    idle(4);

    sel = 1'b1; sym_c = 2; nl_c = 1;
    do_reset(2);
    check_reset_outputs();
    fill(1000);
    run_frame(1000, -1);
    idle(2);

    // Non-coherent-free reference demodulation: correlate with the known carrier
    eprev = 0;
    for (int j = 0; j < 1000; j++) begin
      corr = 0;
      for (int t = 0; t < 2; t++) begin
        int c;
        c = 1 + (1 + j) * 2 + t;
        corr += int'(cap[c + 2]) * ref_sin(lut_idx(c));
      end
      e = (corr < 0) ? 1 : 0;
      bitv = e ^ eprev;
      chk("demod_bit", bitv, int'(fbits[j]));
      eprev = e;
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpsk_mod.md
DPSK_MOD -- requirements
Module: dpsk_mod

Interface
REQ-001 Parameter SYM_CYCLES, default 32: clk cycles per symbol (1 Mbit/s at 32 MHz); legal range 2..65535.
REQ-002 Parameter N_LEAD, default 4: reference symbols (bit 0) sent before the first data bit; legal range 1..255.
REQ-003 Parameter PHASE_INC, default 34'd3221225472: NCO phase increment per clk; 6 MHz at 32 MHz.
REQ-004 clk  input  1  system clock, 32 MHz; single clock domain.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 din  input  1  data bit to transmit.
REQ-007 din_valid  input  1  din is valid.
REQ-008 din_ready  output  1  bit accepted this cycle when din_valid && din_ready.
REQ-009 dout  output  8  signed DPSK-modulated carrier sample, one per clk.
REQ-010 dout_valid  output  1  dout carries a lead or data symbol sample.
REQ-011 busy  output  1  FSM not in IDLE.

Function
REQ-012 The 34-bit phase accumulator shall add PHASE_INC every clk, wrap modulo 2^34, and run continuously from reset, independent of FSM state.
REQ-013 LUT index shall be phase[33:28]; the LUT shall hold 64 entries of round(127*sin(2*pi*k/64)), 8-bit signed.
REQ-014 The FSM shall have states IDLE, LEAD and DATA.
REQ-015 IDLE: din_ready=0 and the modulator holds sym_bit=0; when din_valid=1, the FSM shall enter LEAD next cycle with sym_cnt=0 and lead_cnt=0 without consuming din.
REQ-016 sym_cnt shall count 0..SYM_CYCLES-1 in LEAD and DATA; a symbol boundary is the cycle with sym_cnt=SYM_CYCLES-1.
REQ-017 LEAD: sym_bit=0; lead_cnt shall increment at each boundary.
REQ-018 din_ready shall be 1 only at a boundary in DATA, or at the boundary of the last LEAD symbol (lead_cnt=N_LEAD-1).
REQ-019 At such a boundary with din_valid=1: enc_next = enc XOR din; state becomes DATA; sym_cnt wraps to 0.
REQ-020 At such a boundary with din_valid=0 (underrun or end of frame): state becomes IDLE and enc resets to 0.
REQ-021 Differential encoding: enc is 0 during LEAD, and each new symbol uses enc = enc_prev XOR bit, so a 1 flips the carrier by 180 degrees and a 0 holds phase.
REQ-022 The output path shall be a 2-stage pipeline:
  - stage 1 registers the LUT value and a modulate flag (state is LEAD or DATA) together with enc;
  - stage 2 sets dout = flag ? (enc ? -lut : lut) : 0, and dout_valid = flag.
REQ-023 Negation shall be 8-bit two's complement; the LUT never holds -128, so no overflow occurs.
REQ-024 Symbol transitions shall occur at symbol boundaries only; carrier phase is continuous apart from the 180-degree flip.
REQ-025 A din change while din_ready=0 shall have no effect.

Reset
REQ-026 On rst=1 at a clk edge: phase=0, state=IDLE, sym_cnt=0, lead_cnt=0, enc=0, all pipeline registers cleared.
REQ-027 Output reset values: dout=0, dout_valid=0, din_ready=0, busy=0.
REQ-028 Reset mid-symbol shall abort the transmission immediately; no partial symbol resumes after reset.

Structure
REQ-029 Package dpsk_pkg shall hold:
  - the FSM state typedef;
  - PHASE_W=34;
  - LUT_AW=6;
  - SAMPLE_W=8;
  - the default PHASE_INC constant, shared with the receiver.
REQ-030 The 64-entry sine table shall be a sub-module dpsk_sin_lut (registered read, 1 cycle).

Verification
REQ-031 Reset, then 40 cycles idle -> dout=0, dout_valid=0, din_ready=0 and busy=0 throughout.
REQ-032 Defaults, din_valid=1 held from cycle 0 -> busy rises at cycle 1, dout_valid rises at cycle 3, the first dout values follow LUT indices 12, 24, 36, 48, ... (for example 117, 90, -49), and the first din_ready pulse occurs 128 cycles after LEAD entry.
REQ-033 Bits 1,1,0,1 after the lead -> enc sequence 1,0,0,1; every dout in symbols 1 and 4 equals the negated LUT value; symbols 2 and 3 are unnegated.
REQ-034 din_valid drops before the third data boundary -> din_ready is 1 for one cycle with no transfer, the FSM returns to IDLE, and dout=0 from two cycles later.
REQ-035 rst asserted mid-DATA at sym_cnt=17 -> all outputs are 0 next cycle; restart with din_valid=1 repeats the full N_LEAD lead.
REQ-036 SYM_CYCLES=2, N_LEAD=1, continuous din_valid -> din_ready pulses every 2 cycles, no bit is lost or duplicated over 1000 random bits, and a reference demodulation of dout matches the input bits.
